// File: rtl/axis_merger_counted.sv
// Merges two AXI-Stream inputs into one registered output: FROM_PORT_ZERO beats
// from input 0, then FROM_PORT_ONE beats from input 1, with output_last on the period's final beat.
module axis_merger_counted #(
  parameter int DATA_WIDTH     = 16,
  parameter int FROM_PORT_ZERO = 17,
  parameter int FROM_PORT_ONE  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_0_valid,
  input  logic [DATA_WIDTH-1:0] input_0_data,
  output logic                  input_0_ready,
  input  logic                  input_1_valid,
  input  logic [DATA_WIDTH-1:0] input_1_data,
  output logic                  input_1_ready,
  output logic                  output_valid,
  output logic [DATA_WIDTH-1:0] output_data,
  input  logic                  output_ready,
  output logic                  output_last
);

  localparam int MAX_BEATS = (FROM_PORT_ZERO > FROM_PORT_ONE) ? FROM_PORT_ZERO : FROM_PORT_ONE;
  localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_ZERO = CNT_W'(FROM_PORT_ZERO - 1);
  localparam logic [CNT_W-1:0] LAST_ONE  = CNT_W'(FROM_PORT_ONE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (FROM_PORT_ZERO < 1) begin : g_bad_zero
    $error("FROM_PORT_ZERO must be >= 1");
  end
  if (FROM_PORT_ONE < 1) begin : g_bad_one
    $error("FROM_PORT_ONE must be >= 1");
  end

  typedef enum logic {
    READ_ZERO = 1'b0,
    READ_ONE  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  can_load_s;
  logic                  sel_valid_s;
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  // Readies are gated by rst so neither input can handshake while reset is held
  always_comb begin
    can_load_s    = !valid_q || output_ready;
    input_0_ready = rst && (state_q == READ_ZERO) && can_load_s;
    input_1_ready = rst && (state_q == READ_ONE) && can_load_s;
    case (state_q)
      READ_ZERO: begin
        sel_valid_s = input_0_valid;
        sel_data_s  = input_0_data;
      end
      READ_ONE: begin
        sel_valid_s = input_1_valid;
        sel_data_s  = input_1_data;
      end
      default: begin
        sel_valid_s = 1'b0;
        sel_data_s  = '0;
      end
    endcase
    xfer_s = sel_valid_s && rst && can_load_s;
  end

  // Next-state: load on transfer, drain when the consumer takes the beat, else hold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (xfer_s) begin
      data_d  = sel_data_s;
      valid_d = 1'b1;
      last_d  = (state_q == READ_ONE) && (cnt_q == LAST_ONE);
      case (state_q)
        READ_ZERO: begin
          if (cnt_q == LAST_ZERO) begin
            cnt_d   = '0;
            state_d = READ_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        READ_ONE: begin
          if (cnt_q == LAST_ONE) begin
            cnt_d   = '0;
            state_d = READ_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = READ_ZERO;
        end
      endcase
    end else if (output_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, counter and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= READ_ZERO;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign output_valid = valid_q;
  assign output_data  = data_q;
  assign output_last  = last_q;

  axis_merger_counted_chk #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .input_0_ready(input_0_ready),
    .input_1_ready(input_1_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_last  (output_last)
  );

endmodule

// Protocol checker: at most one input ready, and a stalled beat stays unchanged.
module axis_merger_counted_chk #(
  parameter int DATA_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  input_0_ready,
  input logic                  input_1_ready,
  input logic                  output_valid,
  input logic                  output_ready,
  input logic [DATA_WIDTH-1:0] output_data,
  input logic                  output_last
);

  logic                  hold_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  // Remember whether the output was stalled at the previous edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      hold_q <= output_valid && !output_ready;
      data_q <= output_data;
      last_q <= output_last;
    end
  end

  // Edge-sampled protocol checks
  always @(posedge clk) begin
    if (rst) begin
      assert (!(input_0_ready && input_1_ready));
      if (hold_q) begin
        assert (output_valid && (output_data == data_q) && (output_last == last_q));
      end else begin
        assert (1'b1);
      end
    end else begin
      assert (!input_0_ready && !input_1_ready);
    end
  end

endmodule

// File: tb/tb_axis_merger_counted.sv
// Directed bench for axis_merger_counted: scoreboard of expected merged beats,
// backpressure, starvation, mid-run reset and the 1/1 alternation case.
module tb_axis_merger_counted;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in0_valid, in1_valid, out_ready;
  logic [15:0] in0_data, in1_data;

  logic a_r0, a_r1, a_ov, a_ol;
  logic [15:0] a_od;
  logic b_r0, b_r1, b_ov, b_ol;
  logic [15:0] b_od;

  axis_merger_counted dut (
    .clk(clk), .rst(rst),
    .input_0_valid(in0_valid), .input_0_data(in0_data), .input_0_ready(a_r0),
    .input_1_valid(in1_valid), .input_1_data(in1_data), .input_1_ready(a_r1),
    .output_valid(a_ov), .output_data(a_od), .output_ready(out_ready), .output_last(a_ol)
  );

  axis_merger_counted #(.DATA_WIDTH(16), .FROM_PORT_ZERO(1), .FROM_PORT_ONE(1)) dut_alt (
    .clk(clk), .rst(rst),
    .input_0_valid(in0_valid), .input_0_data(in0_data), .input_0_ready(b_r0),
    .input_1_valid(in1_valid), .input_1_data(in1_data), .input_1_ready(b_r1),
    .output_valid(b_ov), .output_data(b_od), .output_ready(out_ready), .output_last(b_ol)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int z_n = 17;
  int o_n = 5;
  bit sel = 1'b0;
  int i0_val, i1_val, cyc, first_cyc, starve_cnt, guard;
  bit checking, seen_first, prev_hold, expect_full, bp_mode, starve_mode, early_r1, r1_rise_done;
  logic [15:0] prev_d;
  logic prev_l;

  logic m_r0, m_r1, m_ov, m_ol;
  logic [15:0] m_od;
  always_comb begin
    m_r0 = sel ? b_r0 : a_r0;
    m_r1 = sel ? b_r1 : a_r1;
    m_ov = sel ? b_ov : a_ov;
    m_ol = sel ? b_ol : a_ol;
    m_od = sel ? b_od : a_od;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Merged-stream model: beat n of the repeating z_n/o_n pattern
  function automatic beat_t model(input int n);
    int per;
    int k;
    int p;
    beat_t b;
    per = z_n + o_n;
    k = n / per;
    p = n % per;
    if (p < z_n) b.d = 16'(k * z_n + p);
    else b.d = 16'(32'h1000 + k * o_n + (p - z_n));
    b.l = (p == per - 1);
    return b;
  endfunction

  task automatic step();
    logic hs0, hs1, ohs;
    beat_t e;
    @(negedge clk);
    hs0 = in0_valid && m_r0;
    hs1 = in1_valid && m_r1;
    ohs = m_ov && out_ready;
    if (prev_hold) begin
      chk("hold_valid", 32'(m_ov), 32'd1);
      chk("hold_data", 32'(m_od), 32'(prev_d));
      chk("hold_last", 32'(m_ol), 32'(prev_l));
    end
    if (checking && expect_full && seen_first) chk("gap", 32'(m_ov), 32'd1);
    if (m_ov && !seen_first) begin
      seen_first = 1'b1;
      first_cyc = cyc;
    end
    if (early_r1 && i0_val < z_n) chk("r1_early", 32'(m_r1), 32'd0);
    if (early_r1 && i0_val == z_n && i1_val == 0 && !r1_rise_done) begin
      chk("r1_rise", 32'(m_r1), 32'd1);
      r1_rise_done = 1'b1;
    end
    if (starve_mode && !in0_valid) begin
      chk("starve_r1", 32'(m_r1), 32'd0);
      if (starve_cnt >= 2) chk("starve_drain", 32'(m_ov), 32'd0);
    end
    if (ohs && checking && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data", 32'(m_od), 32'(e.d));
      chk("last", 32'(m_ol), 32'(e.l));
    end
    prev_hold = m_ov && !out_ready;
    prev_d = m_od;
    prev_l = m_ol;
    @(posedge clk);
    #1;
    cyc++;
    if (hs0) i0_val++;
    if (hs1) i1_val++;
    in0_data = 16'(i0_val);
    in1_data = 16'(32'h1000 + i1_val);
    if (bp_mode) out_ready = ((cyc / 2) % 2) == 0;
    if (starve_mode) begin
      if (i0_val == 10 && starve_cnt < 8) begin
        in0_valid = 1'b0;
        starve_cnt++;
      end else begin
        in0_valid = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(m_ov), 32'd0);
    chk("rst_last", 32'(m_ol), 32'd0);
    chk("rst_data", 32'(m_od), 32'd0);
    chk("rst_ready0", 32'(m_r0), 32'd0);
    chk("rst_ready1", 32'(m_r1), 32'd0);
    exp_q.delete();
    i0_val = 0;
    i1_val = 0;
    cyc = 0;
    starve_cnt = 0;
    prev_hold = 1'b0;
    seen_first = 1'b0;
    r1_rise_done = 1'b0;
    in0_data = 16'h0000;
    in1_data = 16'h1000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_phase(input int nbeats, input int bound);
    int steps;
    for (int i = 0; i < nbeats; i++) exp_q.push_back(model(i));
    checking = 1'b1;
    steps = 0;
    while (exp_q.size() > 0 && steps < bound) begin
      step();
      steps++;
    end
    chk("beats_left", 32'(exp_q.size()), 32'd0);
    checking = 1'b0;
  endtask

  initial begin
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    out_ready = 1'b1;
    in0_data = 16'h0000;
    in1_data = 16'h1000;
    checking = 1'b0;
    expect_full = 1'b0;
    bp_mode = 1'b0;
    starve_mode = 1'b0;
    early_r1 = 1'b0;
    #3;

    // Full-rate merge with input 1 valid from reset
    early_r1 = 1'b1;
    expect_full = 1'b1;
    do_reset();
    run_phase(44, 200);
    chk("first_latency", 32'(first_cyc), 32'd1);
    chk("r1_rise_seen", 32'(r1_rise_done), 32'd1);
    early_r1 = 1'b0;

    // Output backpressure toggling every two cycles
    bp_mode = 1'b1;
    do_reset();
    run_phase(44, 400);
    bp_mode = 1'b0;
    out_ready = 1'b1;

    // Input 0 starves for 8 cycles after 10 beats
    expect_full = 1'b0;
    starve_mode = 1'b1;
    do_reset();
    run_phase(44, 300);
    chk("starve_cycles", 32'(starve_cnt), 32'd8);
    starve_mode = 1'b0;
    in0_valid = 1'b1;

    // Reset after 20 accepted beats, pattern must restart at input 0
    expect_full = 1'b1;
    do_reset();
    for (int i = 0; i < 44; i++) exp_q.push_back(model(i));
    checking = 1'b1;
    guard = 0;
    while (i0_val + i1_val < 20 && guard < 100) begin
      step();
      guard++;
    end
    chk("pre_reset_in1_beats", 32'(i1_val), 32'd3);
    checking = 1'b0;
    do_reset();
    run_phase(44, 200);

    // FROM_PORT_ZERO = FROM_PORT_ONE = 1: strict alternation
    sel = 1'b1;
    z_n = 1;
    o_n = 1;
    do_reset();
    run_phase(12, 100);
    chk("alt_first_latency", 32'(first_cyc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
